// File: rtl/counter_pkg.sv
// counter_pkg: shared direction type and load-clamp helper for the toggle counter
package counter_pkg;
  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_t;
  function automatic int unsigned clamp_load(input int unsigned value, input int unsigned modulus);
    return (value < modulus) ? value : modulus - 1;
  endfunction
endpackage

// File: rtl/tff_cell.sv
// tff_cell: toggle flip-flop; clk, rst (async high, clears q), t (toggle enable), q (state)
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= 1'b0;
    else if (t) q <= ~q;
endmodule

// File: rtl/tff_updown_counter.sv
// tff_updown_counter: mod-MODULUS up/down counter on a toggle-cell bank; clk, rst (async high), en, up, load, load_val in; q, tc (comb terminal count), wrap (registered wrap pulse) out
module tff_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);
  if (MODULUS < 2 || MODULUS > 2 ** WIDTH) begin : bad_modulus
    $error("tff_updown_counter: MODULUS must lie in 2..2**WIDTH");
  end
  localparam logic [WIDTH:0] top = (WIDTH + 1)'(MODULUS - 1);
  dir_t             dir;
  logic [WIDTH:0]   qx;
  logic [WIDTH-1:0] nxt, up_nxt, dn_nxt, ld_nxt, t;
  assign dir    = dir_t'(up);
  assign qx     = {1'b0, q};
  // >= / > also steer an out-of-range state back into the legal range
  assign up_nxt = (qx >= top) ? '0 : WIDTH'(qx + 1'b1);
  assign dn_nxt = (q == '0 || qx > top) ? WIDTH'(top) : WIDTH'(qx - 1'b1);
  assign ld_nxt = WIDTH'(clamp_load(32'(load_val), MODULUS));
  assign nxt    = load ? ld_nxt : !en ? q : (dir == DIR_UP) ? up_nxt : dn_nxt;
  assign t      = q ^ nxt;
  assign tc     = en & ~load & (((dir == DIR_UP) & (qx == top)) | ((dir == DIR_DOWN) & (q == '0)));
  for (genvar i = 0; i < WIDTH; i++) begin : cells
    tff_cell u_cell (.clk(clk), .rst(rst), .t(t[i]), .q(q[i]));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) wrap <= 1'b0;
    else wrap <= tc;
endmodule
